// File: rtl/ip_pkg.sv
// Shared IP-layer definitions used by the receive steering block and the transmit arbiter.
package ip_pkg;

  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [7:0]  IP_PROTO_ICMP = 8'h01;
  localparam logic [15:0] UDP_HDR_LEN   = 16'd28;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_UDP  = 4'b0010,
    ST_ICMP = 4'b0100,
    ST_DROP = 4'b1000
  } rx_state_t;

  // Protocol field to destination state; unknown protocols are dropped.
  function automatic rx_state_t proto_state(input logic [7:0] proto);
    case (proto)
      IP_PROTO_UDP:  return ST_UDP;
      IP_PROTO_ICMP: return ST_ICMP;
      default:       return ST_DROP;
    endcase
  endfunction

endpackage

// File: rtl/ip_rx_mode_sat_cnt16.sv
// 16-bit saturating event counter with increment enable.
module sat_cnt16 #(
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= INIT;
    else if (inc && (cnt != 16'hffff))
      cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/ip_rx_mode.sv
// Steers the IP receive payload stream to the UDP or ICMP receiver by protocol,
// with per-frame inactivity timeout and saturating frame statistics.
//   state | meaning
//   IDLE  | between frames, waiting for ip_rx_start
//   UDP   | forwarding payload to the UDP port
//   ICMP  | forwarding payload to the ICMP port
//   DROP  | consuming payload of an unsupported protocol
module ip_rx_mode #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hffff,
  parameter logic [15:0] UDP_HDR_LEN    = ip_pkg::UDP_HDR_LEN,
  parameter logic [15:0] STAT_INIT      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ip_rx_start,
  input  logic [7:0]  ip_rx_type,
  input  logic [15:0] ip_rx_length,
  input  logic        ip_rx_valid,
  input  logic [7:0]  ip_rx_data,
  input  logic        ip_rx_end,
  input  logic        ip_rx_error,
  output logic        udp_rx_valid,
  output logic [7:0]  udp_rx_data,
  output logic        udp_rx_end,
  output logic        udp_rx_error,
  output logic [15:0] udp_rx_length,
  output logic        icmp_rx_valid,
  output logic [7:0]  icmp_rx_data,
  output logic        icmp_rx_end,
  output logic        icmp_rx_error,
  output logic [15:0] icmp_rx_length,
  output logic [15:0] udp_frame_cnt,
  output logic [15:0] icmp_frame_cnt,
  output logic [15:0] drop_cnt
);
  import ip_pkg::*;

  rx_state_t   state, state_nxt, start_state;
  logic [15:0] idle_cnt;
  logic        fin, timeout, abort_err, fwd, frame_end, frame_err;
  logic        udp_inc, icmp_inc, drop_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_state = proto_state(ip_rx_type);
    fin         = ip_rx_valid && ip_rx_end;
    timeout     = (state != ST_IDLE) && (idle_cnt == TIMEOUT_CYCLES);
    abort_err   = ip_rx_error || timeout;
    fwd         = (state == ST_UDP) || (state == ST_ICMP);
    frame_end   = fwd && fin && !abort_err;
    // A new start without a closing end byte aborts the frame in flight.
    frame_err   = fwd && (abort_err || (ip_rx_start && !fin));
    if (ip_rx_start)
      state_nxt = start_state;
    else if ((state == ST_DROP) && (ip_rx_end || abort_err))
      state_nxt = ST_IDLE;
    else if (fwd && (fin || abort_err))
      state_nxt = ST_IDLE;
    udp_inc  = (state == ST_UDP) && frame_end;
    icmp_inc = (state == ST_ICMP) && frame_end;
    drop_inc = ip_rx_start && (start_state == ST_DROP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt       <= '0;
      udp_rx_valid   <= 1'b0;
      udp_rx_data    <= '0;
      udp_rx_end     <= 1'b0;
      udp_rx_error   <= 1'b0;
      udp_rx_length  <= '0;
      icmp_rx_valid  <= 1'b0;
      icmp_rx_data   <= '0;
      icmp_rx_end    <= 1'b0;
      icmp_rx_error  <= 1'b0;
      icmp_rx_length <= '0;
    end else begin
      if ((state == ST_IDLE) || ip_rx_valid || ip_rx_start)
        idle_cnt <= '0;
      else if (idle_cnt != 16'hffff)
        idle_cnt <= idle_cnt + 16'd1;

      udp_rx_valid  <= (state == ST_UDP) && ip_rx_valid;
      udp_rx_data   <= ((state == ST_UDP) && ip_rx_valid) ? ip_rx_data : 8'h00;
      udp_rx_end    <= (state == ST_UDP) && frame_end;
      udp_rx_error  <= (state == ST_UDP) && frame_err;
      icmp_rx_valid <= (state == ST_ICMP) && ip_rx_valid;
      icmp_rx_data  <= ((state == ST_ICMP) && ip_rx_valid) ? ip_rx_data : 8'h00;
      icmp_rx_end   <= (state == ST_ICMP) && frame_end;
      icmp_rx_error <= (state == ST_ICMP) && frame_err;

      if (ip_rx_start) begin
        udp_rx_length  <= (ip_rx_length < UDP_HDR_LEN) ? 16'd0 : ip_rx_length - UDP_HDR_LEN;
        icmp_rx_length <= ip_rx_length;
      end
    end
  end

  sat_cnt16 #(.INIT(STAT_INIT)) u_udp_cnt (
    .clk(clk), .rst(rst), .inc(udp_inc), .cnt(udp_frame_cnt)
  );

  sat_cnt16 #(.INIT(STAT_INIT)) u_icmp_cnt (
    .clk(clk), .rst(rst), .inc(icmp_inc), .cnt(icmp_frame_cnt)
  );

  sat_cnt16 #(.INIT(STAT_INIT)) u_drop_cnt (
    .clk(clk), .rst(rst), .inc(drop_inc), .cnt(drop_cnt)
  );

endmodule

// File: tb/tb_ip_rx_mode.sv
// Scoreboard bench for ip_rx_mode: a cycle model predicts each port's output beats.
module tb_ip_rx_mode;
  import ip_pkg::*;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e;
    logic       er;
    int         c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ip_rx_start = 1'b0;
  logic [7:0]  ip_rx_type = '0;
  logic [15:0] ip_rx_length = '0;
  logic        ip_rx_valid = 1'b0;
  logic [7:0]  ip_rx_data = '0;
  logic        ip_rx_end = 1'b0;
  logic        ip_rx_error = 1'b0;

  logic        udp_rx_valid, udp_rx_end, udp_rx_error;
  logic [7:0]  udp_rx_data;
  logic [15:0] udp_rx_length;
  logic        icmp_rx_valid, icmp_rx_end, icmp_rx_error;
  logic [7:0]  icmp_rx_data;
  logic [15:0] icmp_rx_length;
  logic [15:0] udp_frame_cnt, icmp_frame_cnt, drop_cnt;

  logic        s_udp_valid, s_udp_end, s_udp_error;
  logic [7:0]  s_udp_data;
  logic [15:0] s_udp_length;
  logic        s_icmp_valid, s_icmp_end, s_icmp_error;
  logic [7:0]  s_icmp_data;
  logic [15:0] s_icmp_length;
  logic [15:0] s_udp_frame_cnt, s_icmp_frame_cnt, s_drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q_udp[$];
  exp_t q_icmp[$];
  exp_t mx_u, mx_i;

  int          mst = 0;      // 0 idle, 1 udp, 2 icmp, 3 drop
  logic [15:0] mcnt = '0;

  localparam logic [15:0] TO = 16'd16;

  ip_rx_mode #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ip_rx_start(ip_rx_start), .ip_rx_type(ip_rx_type), .ip_rx_length(ip_rx_length),
    .ip_rx_valid(ip_rx_valid), .ip_rx_data(ip_rx_data), .ip_rx_end(ip_rx_end),
    .ip_rx_error(ip_rx_error),
    .udp_rx_valid(udp_rx_valid), .udp_rx_data(udp_rx_data), .udp_rx_end(udp_rx_end),
    .udp_rx_error(udp_rx_error), .udp_rx_length(udp_rx_length),
    .icmp_rx_valid(icmp_rx_valid), .icmp_rx_data(icmp_rx_data), .icmp_rx_end(icmp_rx_end),
    .icmp_rx_error(icmp_rx_error), .icmp_rx_length(icmp_rx_length),
    .udp_frame_cnt(udp_frame_cnt), .icmp_frame_cnt(icmp_frame_cnt), .drop_cnt(drop_cnt)
  );

  // Second instance with counters preloaded near saturation.
  ip_rx_mode #(.TIMEOUT_CYCLES(TO), .STAT_INIT(16'hfffe)) dut_sat (
    .clk(clk), .rst(rst),
    .ip_rx_start(ip_rx_start), .ip_rx_type(ip_rx_type), .ip_rx_length(ip_rx_length),
    .ip_rx_valid(ip_rx_valid), .ip_rx_data(ip_rx_data), .ip_rx_end(ip_rx_end),
    .ip_rx_error(ip_rx_error),
    .udp_rx_valid(s_udp_valid), .udp_rx_data(s_udp_data), .udp_rx_end(s_udp_end),
    .udp_rx_error(s_udp_error), .udp_rx_length(s_udp_length),
    .icmp_rx_valid(s_icmp_valid), .icmp_rx_data(s_icmp_data), .icmp_rx_end(s_icmp_end),
    .icmp_rx_error(s_icmp_error), .icmp_rx_length(s_icmp_length),
    .udp_frame_cnt(s_udp_frame_cnt), .icmp_frame_cnt(s_icmp_frame_cnt), .drop_cnt(s_drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      while (q_udp.size() > 0 && q_udp[0].c < cyc) begin
        mx_u = q_udp.pop_front();
        checks++; errors++;
        $display("FAIL udp_missing beat d=%h e=%0b er=%0b due cycle %0d, now %0d", mx_u.d, mx_u.e, mx_u.er, mx_u.c, cyc);
      end
      while (q_icmp.size() > 0 && q_icmp[0].c < cyc) begin
        mx_i = q_icmp.pop_front();
        checks++; errors++;
        $display("FAIL icmp_missing beat d=%h e=%0b er=%0b due cycle %0d, now %0d", mx_i.d, mx_i.e, mx_i.er, mx_i.c, cyc);
      end
      if (udp_rx_valid || udp_rx_end || udp_rx_error) begin
        checks++;
        if (q_udp.size() == 0) begin
          errors++;
          $display("FAIL udp_unexpected got v=%0b d=%h e=%0b er=%0b, required no beat", udp_rx_valid, udp_rx_data, udp_rx_end, udp_rx_error);
        end else begin
          mx_u = q_udp.pop_front();
          if (udp_rx_valid !== mx_u.v || udp_rx_data !== mx_u.d || udp_rx_end !== mx_u.e ||
              udp_rx_error !== mx_u.er || cyc != mx_u.c) begin
            errors++;
            $display("FAIL udp_beat got v=%0b d=%h e=%0b er=%0b cyc=%0d, required v=%0b d=%h e=%0b er=%0b cyc=%0d",
                     udp_rx_valid, udp_rx_data, udp_rx_end, udp_rx_error, cyc, mx_u.v, mx_u.d, mx_u.e, mx_u.er, mx_u.c);
          end
        end
      end
      if (icmp_rx_valid || icmp_rx_end || icmp_rx_error) begin
        checks++;
        if (q_icmp.size() == 0) begin
          errors++;
          $display("FAIL icmp_unexpected got v=%0b d=%h e=%0b er=%0b, required no beat", icmp_rx_valid, icmp_rx_data, icmp_rx_end, icmp_rx_error);
        end else begin
          mx_i = q_icmp.pop_front();
          if (icmp_rx_valid !== mx_i.v || icmp_rx_data !== mx_i.d || icmp_rx_end !== mx_i.e ||
              icmp_rx_error !== mx_i.er || cyc != mx_i.c) begin
            errors++;
            $display("FAIL icmp_beat got v=%0b d=%h e=%0b er=%0b cyc=%0d, required v=%0b d=%h e=%0b er=%0b cyc=%0d",
                     icmp_rx_valid, icmp_rx_data, icmp_rx_end, icmp_rx_error, cyc, mx_i.v, mx_i.d, mx_i.e, mx_i.er, mx_i.c);
          end
        end
      end
      if (!udp_rx_valid && udp_rx_data !== 8'h00) begin
        checks++; errors++;
        $display("FAIL udp_data_idle got %h required 00", udp_rx_data);
      end
      if (!icmp_rx_valid && icmp_rx_data !== 8'h00) begin
        checks++; errors++;
        $display("FAIL icmp_data_idle got %h required 00", icmp_rx_data);
      end
    end
  end

  // Drive one cycle of input and advance the reference model.
  task automatic step(input logic s, input logic [7:0] t, input logic [15:0] l,
                      input logic v, input logic [7:0] d, input logic e, input logic er);
    exp_t x;
    logic fin, ea, fwd, fe, ferr;
    int nst;
    @(posedge clk); #1;
    ip_rx_start = s; ip_rx_type = t; ip_rx_length = l;
    ip_rx_valid = v; ip_rx_data = d; ip_rx_end = e; ip_rx_error = er;
    fin  = v && e;
    ea   = er || (mst != 0 && mcnt == TO);
    fwd  = (mst == 1) || (mst == 2);
    fe   = fwd && fin && !ea;
    ferr = fwd && (ea || (s && !fin));
    if (fwd && (v || fe || ferr)) begin
      x.v = v; x.d = v ? d : 8'h00; x.e = fe; x.er = ferr; x.c = cyc + 1;
      if (mst == 1) q_udp.push_back(x);
      else q_icmp.push_back(x);
    end
    if (s) begin
      if (t == 8'h11) nst = 1;
      else if (t == 8'h01) nst = 2;
      else nst = 3;
    end else if (mst == 3 && (e || ea)) nst = 0;
    else if (fwd && (fin || ea)) nst = 0;
    else nst = mst;
    if (mst == 0 || v || s) mcnt = '0;
    else if (mcnt != 16'hffff) mcnt = mcnt + 16'd1;
    mst = nst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 16'd0, 0, 8'h00, 0, 0);
  endtask

  task automatic bytes(input logic [7:0] base, input int n, input logic with_end);
    for (int i = 0; i < n; i++)
      step(0, 8'h00, 16'd0, 1, 8'(base + 8'(i)), with_end && (i == n - 1), 0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    ip_rx_start = 0; ip_rx_valid = 0; ip_rx_end = 0; ip_rx_error = 0; ip_rx_data = '0;
    q_udp.delete(); q_icmp.delete(); mst = 0; mcnt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({udp_rx_valid, udp_rx_data, udp_rx_end, udp_rx_error} !== 11'd0) begin
      errors++; $display("FAIL reset_udp_stream got %b required 0", {udp_rx_valid, udp_rx_data, udp_rx_end, udp_rx_error});
    end
    checks++;
    if ({icmp_rx_valid, icmp_rx_data, icmp_rx_end, icmp_rx_error} !== 11'd0) begin
      errors++; $display("FAIL reset_icmp_stream got %b required 0", {icmp_rx_valid, icmp_rx_data, icmp_rx_end, icmp_rx_error});
    end
    checks++;
    if (udp_rx_length !== 16'd0 || icmp_rx_length !== 16'd0) begin
      errors++; $display("FAIL reset_lengths got %h/%h required 0000/0000", udp_rx_length, icmp_rx_length);
    end
    checks++;
    if (udp_frame_cnt !== 16'd0 || icmp_frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters got %h/%h/%h required 0", udp_frame_cnt, icmp_frame_cnt, drop_cnt);
    end
    checks++;
    if (dut.state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state got %b required %b", dut.state, ST_IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic test_udp();
    step(1, 8'h11, 16'd40, 0, 8'h00, 0, 0);
    bytes(8'hA0, 12, 1);
    idle(3);
    checks++;
    if (udp_rx_length !== 16'd12) begin
      errors++; $display("FAIL udp_length got %0d required 12", udp_rx_length);
    end
    checks++;
    if (udp_frame_cnt !== 16'd1 || icmp_frame_cnt !== 16'd0) begin
      errors++; $display("FAIL udp_frame_cnt got %0d/%0d required 1/0", udp_frame_cnt, icmp_frame_cnt);
    end
  endtask

  task automatic test_icmp();
    step(1, 8'h01, 16'd32, 0, 8'h00, 0, 0);
    bytes(8'h10, 32, 1);
    idle(3);
    checks++;
    if (icmp_rx_length !== 16'd32) begin
      errors++; $display("FAIL icmp_length got %0d required 32", icmp_rx_length);
    end
    checks++;
    if (icmp_frame_cnt !== 16'd1 || udp_frame_cnt !== 16'd1) begin
      errors++; $display("FAIL icmp_frame_cnt got %0d/%0d required 1/1", icmp_frame_cnt, udp_frame_cnt);
    end
  endtask

  task automatic test_drop();
    step(1, 8'h06, 16'd40, 0, 8'h00, 0, 0);
    bytes(8'h50, 20, 1);
    idle(2);
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++; $display("FAIL drop_cnt got %0d required 1", drop_cnt);
    end
    checks++;
    if (dut.state !== ST_IDLE) begin
      errors++; $display("FAIL drop_idle got %b required %b", dut.state, ST_IDLE);
    end
  endtask

  task automatic test_error();
    step(1, 8'h11, 16'd50, 0, 8'h00, 0, 0);
    bytes(8'hC0, 5, 0);
    step(0, 8'h00, 16'd0, 0, 8'h00, 0, 1);
    idle(2);
    checks++;
    if (udp_frame_cnt !== 16'd1 || dut.state !== ST_IDLE) begin
      errors++; $display("FAIL error_abort got cnt=%0d state=%b required cnt=1 state=%b", udp_frame_cnt, dut.state, ST_IDLE);
    end
    step(1, 8'h01, 16'd24, 0, 8'h00, 0, 0);
    bytes(8'hD0, 4, 1);
    idle(2);
    checks++;
    if (icmp_frame_cnt !== 16'd2) begin
      errors++; $display("FAIL error_next_icmp got %0d required 2", icmp_frame_cnt);
    end
    // Error arriving with a valid byte forwards that byte alongside the error.
    step(1, 8'h11, 16'd50, 0, 8'h00, 0, 0);
    bytes(8'hE0, 2, 0);
    step(0, 8'h00, 16'd0, 1, 8'hE2, 0, 1);
    idle(2);
    checks++;
    if (udp_frame_cnt !== 16'd1) begin
      errors++; $display("FAIL error_with_byte_cnt got %0d required 1", udp_frame_cnt);
    end
  endtask

  task automatic test_timeout();
    step(1, 8'h11, 16'd10, 0, 8'h00, 0, 0);
    idle(1);
    checks++;
    if (udp_rx_length !== 16'd0) begin
      errors++; $display("FAIL short_udp_length got %0d required 0", udp_rx_length);
    end
    bytes(8'h70, 3, 0);
    idle(20);
    checks++;
    if (dut.state !== ST_IDLE || udp_frame_cnt !== 16'd1) begin
      errors++; $display("FAIL timeout_abort got state=%b cnt=%0d required state=%b cnt=1", dut.state, udp_frame_cnt, ST_IDLE);
    end
    step(1, 8'h07, 16'd40, 0, 8'h00, 0, 0);
    bytes(8'h80, 2, 0);
    idle(20);
    checks++;
    if (dut.state !== ST_IDLE || drop_cnt !== 16'd2) begin
      errors++; $display("FAIL drop_timeout got state=%b drop=%0d required state=%b drop=2", dut.state, drop_cnt, ST_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 8'h11, 16'd30, 0, 8'h00, 0, 0);
    step(0, 8'h00, 16'd0, 1, 8'hB0, 0, 0);
    checks++;
    if (udp_rx_length !== 16'd2) begin
      errors++; $display("FAIL b2b_udp_length got %0d required 2", udp_rx_length);
    end
    step(1, 8'h01, 16'd20, 1, 8'hB1, 1, 0);
    bytes(8'hB8, 3, 1);
    idle(2);
    checks++;
    if (udp_frame_cnt !== 16'd2 || icmp_frame_cnt !== 16'd3) begin
      errors++; $display("FAIL b2b_counts got %0d/%0d required 2/3", udp_frame_cnt, icmp_frame_cnt);
    end
    // A start without end aborts the UDP frame and routes the new one at once.
    step(1, 8'h11, 16'd60, 0, 8'h00, 0, 0);
    bytes(8'h90, 2, 0);
    step(1, 8'h01, 16'd8, 0, 8'h00, 0, 0);
    bytes(8'h98, 2, 1);
    idle(2);
    checks++;
    if (udp_frame_cnt !== 16'd2 || icmp_frame_cnt !== 16'd4) begin
      errors++; $display("FAIL start_abort_counts got %0d/%0d required 2/4", udp_frame_cnt, icmp_frame_cnt);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    checks++;
    if (s_udp_frame_cnt !== 16'hfffe) begin
      errors++; $display("FAIL sat_preload got %h required fffe", s_udp_frame_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      step(1, 8'h11, 16'd29, 0, 8'h00, 0, 0);
      bytes(8'h40, 1, 1);
      idle(1);
      checks++;
      if (s_udp_frame_cnt !== 16'hffff) begin
        errors++; $display("FAIL sat_udp frame %0d got %h required ffff", k, s_udp_frame_cnt);
      end
    end
    for (int k = 0; k < 3; k++) step(1, 8'h22, 16'd40, 0, 8'h00, 0, 0);
    step(0, 8'h00, 16'd0, 1, 8'h00, 1, 0);
    idle(1);
    checks++;
    if (s_drop_cnt !== 16'hffff || drop_cnt !== 16'd3) begin
      errors++; $display("FAIL sat_drop got %h/%h required ffff/0003", s_drop_cnt, drop_cnt);
    end
    checks++;
    if (udp_frame_cnt !== 16'd3) begin
      errors++; $display("FAIL sat_main_udp got %0d required 3", udp_frame_cnt);
    end
  endtask

  task automatic test_async_reset();
    step(1, 8'h11, 16'd40, 0, 8'h00, 0, 0);
    step(0, 8'h00, 16'd0, 1, 8'h55, 0, 0);
    step(0, 8'h00, 16'd0, 0, 8'h00, 0, 0);
    #1;
    checks++;
    if (udp_rx_valid !== 1'b1 || udp_rx_data !== 8'h55) begin
      errors++; $display("FAIL pre_reset_beat got v=%0b d=%h required v=1 d=55", udp_rx_valid, udp_rx_data);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({udp_rx_valid, udp_rx_data, udp_rx_end, udp_rx_error, udp_rx_length} !== 27'd0) begin
      errors++; $display("FAIL async_reset_udp got v=%0b d=%h len=%0d required 0", udp_rx_valid, udp_rx_data, udp_rx_length);
    end
    checks++;
    if (udp_frame_cnt !== 16'd0 || drop_cnt !== 16'd0 || dut.state !== ST_IDLE) begin
      errors++; $display("FAIL async_reset_state got cnt=%0d drop=%0d state=%b required 0/0/%b", udp_frame_cnt, drop_cnt, dut.state, ST_IDLE);
    end
    q_udp.delete(); q_icmp.delete(); mst = 0; mcnt = '0;
    ip_rx_valid = 0; ip_rx_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(1, 8'h01, 16'd12, 0, 8'h00, 0, 0);
    bytes(8'h60, 2, 1);
    idle(2);
    checks++;
    if (icmp_frame_cnt !== 16'd1) begin
      errors++; $display("FAIL post_reset_icmp got %0d required 1", icmp_frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_udp();
    test_icmp();
    test_drop();
    test_error();
    test_timeout();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    idle(3);
    checks++;
    if (q_udp.size() != 0 || q_icmp.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d/%0d pending required 0/0", q_udp.size(), q_icmp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/ip_rx_mode.md
Name: ip_rx_mode

Overview:
Receive-side counterpart of the IP transmit arbiter. It takes the single IP-layer receive byte stream and steers each frame's payload to the UDP or ICMP receiver, selected by the IP protocol field (0x11 UDP, 0x01 ICMP). Frames with any other protocol are discarded and counted. It sits between the IP receive parser and the udp_rx / icmp_rx blocks, and adds a per-frame timeout guard and saturating frame statistics.

Parameters:
TIMEOUT_CYCLES, 16'hffff, number of consecutive cycles without ip_rx_valid inside a frame before the frame is aborted
UDP_HDR_LEN, 28, bytes subtracted from the IP total length to give the UDP payload length (IP header 20 plus UDP header 8)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
ip_rx_start  in  1  one-cycle pulse at frame start; qualifies ip_rx_type and ip_rx_length
ip_rx_type  in  8  IP protocol field, sampled on ip_rx_start
ip_rx_length  in  16  IP total length, sampled on ip_rx_start
ip_rx_valid  in  1  payload byte valid
ip_rx_data  in  8  payload byte
ip_rx_end  in  1  marks the last byte; coincident with ip_rx_valid
ip_rx_error  in  1  upstream abort pulse (checksum or length error)
udp_rx_valid / udp_rx_data / udp_rx_end / udp_rx_error  out  1/8/1/1  UDP-side stream
udp_rx_length  out  16  UDP payload length
icmp_rx_valid / icmp_rx_data / icmp_rx_end / icmp_rx_error  out  1/8/1/1  ICMP-side stream
icmp_rx_length  out  16  ICMP length; ip_rx_length passed through unchanged
udp_frame_cnt, icmp_frame_cnt, drop_cnt  out  16 each  saturating statistics

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset is asynchronous and may hit mid-frame; it abandons the frame with no end or error pulse.
- FSM is one-hot with four states: IDLE, UDP, ICMP, DROP.
- IDLE, on ip_rx_start: type 0x11 goes to UDP, type 0x01 goes to ICMP, any other type goes to DROP.
  - Entering DROP increments drop_cnt.
  - Type and length are latched in the same cycle.
- udp_rx_length = latched length - UDP_HDR_LEN, clamped to 0 when latched length < UDP_HDR_LEN. It is registered and valid from the first udp_rx_valid until the next start.
- UDP / ICMP data path:
  - ip_rx_valid, ip_rx_data and ip_rx_end are registered once and appear on the selected port with exactly 1 cycle of latency.
  - The non-selected port holds valid, end, error and data at 0.
  - Data outputs read 0 whenever valid is 0.
- Frame end: ip_rx_valid together with ip_rx_end returns the FSM to IDLE. The selected end pulse is emitted on the next cycle, together with the last byte. The matching frame counter increments in that same cycle.
- DROP: input bytes are consumed and nothing is output. ip_rx_end, ip_rx_error or timeout returns the FSM to IDLE.
- ip_rx_error in UDP or ICMP:
  - Go to IDLE and emit a 1-cycle error pulse on the selected port on the next cycle.
  - If a valid byte arrives in the same cycle, it is forwarded together with that error pulse.
  - No end pulse is emitted and the frame counter does not increment.
- Timeout:
  - An idle counter resets on every ip_rx_valid and increments on every other non-IDLE cycle.
  - When it reaches TIMEOUT_CYCLES: go to IDLE and treat the frame as an ip_rx_error (error pulse in UDP/ICMP, silent in DROP).
  - The counter clears in IDLE.
- ip_rx_start while not in IDLE and without ip_rx_end in the same cycle:
  - Abort the current frame exactly as for ip_rx_error.
  - Decode the new frame in the same cycle and move directly to its state, with no IDLE cycle in between.
- ip_rx_end together with ip_rx_start: the current frame completes normally and the new frame is decoded in the same cycle.
- Counters saturate at 16'hffff and never wrap.

Decomposition:
- Shared package ip_pkg holds:
  - protocol constants IP_PROTO_UDP = 8'h11 and IP_PROTO_ICMP = 8'h01;
  - UDP_HDR_LEN;
  - the state encoding.
  The transmit arbiter uses the same constants.
- One sub-module, sat_cnt16: a 16-bit saturating counter with an increment enable. It is instantiated three times.

Test Plan:
1. Start with type 0x11 and length 40, then 12 bytes A0..AB with end on AB -> udp_rx_valid for 12 cycles, 1 cycle after the input; udp_rx_length = 12; udp_rx_end on AB; udp_frame_cnt = 1; icmp outputs stay 0.
2. Start with type 0x01 and length 32, then 32 bytes -> same 1-cycle latency on the ICMP port; icmp_rx_length = 32; icmp_frame_cnt = 1.
3. Start with type 0x06, then 20 bytes and end -> no output valid on either port; drop_cnt = 1; FSM back in IDLE.
4. UDP frame with ip_rx_error after byte 5 -> 5 bytes out, udp_rx_error pulse, no udp_rx_end, udp_frame_cnt unchanged; a following ICMP frame is routed correctly.
5. TIMEOUT_CYCLES = 16; UDP frame stalls after 3 bytes -> udp_rx_error exactly when the idle counter reaches 16; then IDLE. Also: start with type 0x11 and length 10 -> udp_rx_length = 0.
6. End and start in the same cycle (UDP followed by ICMP) -> udp_rx_end, then ICMP bytes with no gap. Also: preload the counter to 16'hfffe, run 3 frames -> counter holds at 16'hffff. Also: rst asserted mid-frame -> all outputs 0 asynchronously.
